// File: rtl/bht_update_queue.sv
// bht_update_queue: buffers resolved branch outcomes and drains one per cycle into the BHT.
// Ports: clk_i/rst_ni (async active-low) clock and reset; flush_i drops all queued entries;
// debug_mode_i pops entries without issuing them; resolve_*_i carry NR_PORTS resolutions per cycle,
// port 0 oldest; resolve_ready_o says all ports may push; bht_update_o drives the BHT;
// ghr_o is the committed global history, newest outcome in bit 0.
// Define BHT_UPD_BYPASS_EN to forward the oldest valid port straight to the BHT when the queue is empty.
package riscv;
    localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
    typedef struct packed {
        logic                   valid;
        logic [riscv::VLEN-1:0] pc;
        logic                   taken;
    } bht_update_t;
endpackage

module bht_update_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned HIST_LEN = 10
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic                                 debug_mode_i,
    input  logic [NR_PORTS-1:0]                  resolve_valid_i,
    input  logic [NR_PORTS-1:0][riscv::VLEN-1:0] resolve_pc_i,
    input  logic [NR_PORTS-1:0]                  resolve_taken_i,
    output logic                                 resolve_ready_o,
    output ariane_pkg::bht_update_t              bht_update_o,
    output logic [HIST_LEN-1:0]                  ghr_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [riscv::VLEN-1:0]           pc_q [DEPTH];
    logic [DEPTH-1:0]                 taken_q;
    logic [AW-1:0]                    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]                    count_q, n_store;
    logic [HIST_LEN-1:0]              ghr_q;
    logic [NR_PORTS-1:0]              push, store;
    logic [NR_PORTS-1:0][AW-1:0]      slot;
    logic                             empty, pop, out_valid, out_taken, upd_valid;
    logic [riscv::VLEN-1:0]           out_pc;

    assign empty           = count_q == '0;
    assign pop             = !empty && !flush_i;
    assign resolve_ready_o = (DEPTH - 32'(count_q)) >= NR_PORTS;

`ifdef BHT_UPD_BYPASS_EN
    logic [NR_PORTS-1:0]    byp_sel;
    logic [riscv::VLEN-1:0] byp_pc;
    logic                   byp_taken, byp_hit;
    // isolate the lowest set bit: the oldest valid port
    assign byp_sel = resolve_valid_i & ~(resolve_valid_i - NR_PORTS'(1));
    assign byp_hit = empty && !flush_i && (|resolve_valid_i);
    always_comb begin
        byp_pc    = '0;
        byp_taken = 1'b0;
        for (int i = 0; i < NR_PORTS; i++) begin
            if (byp_sel[i]) begin
                byp_pc    = resolve_pc_i[i];
                byp_taken = resolve_taken_i[i];
            end
        end
    end
    assign push      = byp_hit ? resolve_valid_i & ~byp_sel : resolve_valid_i;
    assign out_valid = !flush_i && (!empty || byp_hit);
    assign out_pc    = empty ? byp_pc : pc_q[rd_ptr_q];
    assign out_taken = empty ? byp_taken : taken_q[rd_ptr_q];
`else
    assign push      = resolve_valid_i;
    assign out_valid = pop;
    assign out_pc    = pc_q[rd_ptr_q];
    assign out_taken = taken_q[rd_ptr_q];
`endif

    // invalid updates are driven as all-zero so nothing stale leaks to the BHT
    assign upd_valid          = out_valid && !debug_mode_i;
    assign bht_update_o.valid = upd_valid;
    assign bht_update_o.pc    = upd_valid ? out_pc : '0;
    assign bht_update_o.taken = upd_valid && out_taken;
    assign ghr_o              = ghr_q;

    // compact stored ports into consecutive slots starting at the write pointer
    always_comb begin
        n_store = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            store[i] = push[i] && resolve_ready_o && !flush_i;
            slot[i]  = wr_ptr_q + n_store[AW-1:0];
            n_store  = n_store + CW'(store[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_PORTS; i++) begin
            if (store[i]) begin
                pc_q[slot[i]]    <= resolve_pc_i[i];
                taken_q[slot[i]] <= resolve_taken_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (flush_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_q + n_store - CW'(pop);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            wr_ptr_q <= wr_ptr_q + n_store[AW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ghr_q <= '0;
        else if (upd_valid) ghr_q <= {ghr_q[HIST_LEN-2:0], out_taken};
    end
endmodule
